adder_op_sequencer: RTL and testbench

- Upstream master for the 8-bit register-mapped full adder.
- Accepts one operation (A, B, cin) on a valid/ready request port.
- Performs register writes DATA1 (0x01), DATA2 (0x02) and CIN (0x03), pulses start, waits for the adder's ready strobe, then reads RESULT (0x04) and COUT (0x05).
- Returns sum/carry on a valid/ready response port, decoupling the client from the adder's register protocol.

---
 rtl/adder_op_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_adder_op_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_op_sequencer.sv
// Request/response front end that drives the register-mapped 8-bit adder: writes operands, starts, reads back.
// Optional watchdog on ack/ready waits is compiled in with `define ADDER_SEQ_WDOG_EN.
module adder_op_sequencer #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [N-1:0] i_op_a,
    input  logic [N-1:0] i_op_b,
    input  logic         i_cin,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [N-1:0] o_rsp_sum,
    output logic         o_rsp_cout,
    output logic         o_rsp_err,
    output logic [2:0]   o_addr,
    output logic [N-1:0] o_data,
    output logic         o_we,
    output logic         o_start,
    input  logic [N-1:0] i_data,
    input  logic         i_ack,
    input  logic         i_ready
);

    if (N < 2 || (N % 2) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("adder_op_sequencer: N must be even and >= 2, TIMEOUT >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WR_D1, S_WR_D2, S_WR_CIN, S_START,
        S_WAIT_RDY, S_RD_RES, S_RD_COUT, S_RSP
    } state_t;

    state_t       state_q, state_d;
    logic         phase_q, phase_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic         cin_q, cin_d;
    logic [2:0]   addr_q, addr_d;
    logic [N-1:0] data_q, data_d;
    logic         we_q, we_d, start_q, start_d, rsp_valid_q, rsp_valid_d;
    logic [N-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;

`ifdef ADDER_SEQ_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            timeout;
`endif

    function automatic logic is_wr(state_t s);
        return (s == S_WR_D1) || (s == S_WR_D2) || (s == S_WR_CIN);
    endfunction

    function automatic state_t wr_next(state_t s);
        case (s)
            S_WR_D1: return S_WR_D2;
            S_WR_D2: return S_WR_CIN;
            default: return S_START;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADDER_SEQ_WDOG_EN
        err_d   = err_q;
        timeout = 1'b0;
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    a_d     = i_op_a;
                    b_d     = i_op_b;
                    cin_d   = i_cin;
                    state_d = S_WR_D1;
                    phase_d = 1'b0;
`ifdef ADDER_SEQ_WDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            // Phase 0 issues the write strobe; phase 1 holds the bus until the ack.
            S_WR_D1, S_WR_D2, S_WR_CIN: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (i_ack) begin
                    state_d = wr_next(state_q);
                    phase_d = 1'b0;
                end
`ifdef ADDER_SEQ_WDOG_EN
                else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                end
`endif
            end
            S_START: state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (i_ready) begin
                    state_d = S_RD_RES;
                    phase_d = 1'b0;
                end
`ifdef ADDER_SEQ_WDOG_EN
                else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                end
`endif
            end
            S_RD_RES: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    sum_d   = i_data;
                    state_d = S_RD_COUT;
                    phase_d = 1'b0;
                end
            end
            S_RD_COUT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    cout_d  = i_data[0];
                    state_d = S_RSP;
                    phase_d = 1'b0;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end
        endcase

`ifdef ADDER_SEQ_WDOG_EN
        if (timeout) begin
            state_d = S_RSP;
            phase_d = 1'b0;
            err_d   = 1'b1;
            sum_d   = '0;
            cout_d  = 1'b0;
        end
        if ((state_d == S_WAIT_RDY && state_q != S_WAIT_RDY) ||
            (is_wr(state_d) && phase_d && !phase_q)) begin
            wd_d = '0;
        end else if (state_d == state_q &&
                     (state_q == S_WAIT_RDY || (is_wr(state_q) && phase_q))) begin
            wd_d = wd_q + WD_W'(1);
        end
`endif

        // Bus and response outputs are decoded from the next state so they appear registered.
        addr_d      = 3'd0;
        data_d      = '0;
        we_d        = 1'b0;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_d)
            S_WR_D1:   begin addr_d = 3'd1; data_d = a_d; we_d = !phase_d; end
            S_WR_D2:   begin addr_d = 3'd2; data_d = b_d; we_d = !phase_d; end
            S_WR_CIN:  begin addr_d = 3'd3; data_d = {{(N-1){1'b0}}, cin_d}; we_d = !phase_d; end
            S_START:   start_d = 1'b1;
            S_RD_RES:  addr_d = 3'd4;
            S_RD_COUT: addr_d = 3'd5;
            S_RSP:     rsp_valid_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            addr_q      <= 3'd0;
            data_q      <= '0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef ADDER_SEQ_WDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef ADDER_SEQ_WDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_sum   = sum_q;
    assign o_rsp_cout  = cout_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_we        = we_q;
    assign o_start     = start_q;
`ifdef ADDER_SEQ_WDOG_EN
    assign o_rsp_err   = err_q;
`else
    assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Scoreboard bench for adder_op_sequencer with a small register-mapped adder model.
module tb_adder_op_sequencer;
    localparam int N = 8;

    logic         clk = 1'b0, rstn = 1'b0;
    logic         req_valid = 1'b0, rsp_ready = 1'b0, cin = 1'b0;
    logic [N-1:0] op_a = '0, op_b = '0;
    logic         req_ready, rsp_valid, rsp_cout, rsp_err, we, start;
    logic [N-1:0] rsp_sum, wdata;
    logic [2:0]   addr;
    logic [N-1:0] rdata;
    logic         ack, ready;

    always #5 clk = ~clk;

    adder_op_sequencer #(.N(N), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_op_a(op_a), .i_op_b(op_b), .i_cin(cin),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_rsp_err(rsp_err),
        .o_addr(addr), .o_data(wdata), .o_we(we), .o_start(start),
        .i_data(rdata), .i_ack(ack), .i_ready(ready)
    );

    // Adder model: registered ack, ready two cycles after start, registered read data.
    logic [N-1:0] r1, r2, data_m;
    logic         r3, st1, ack_m, rdy_m;
    logic         never_ready = 1'b0, sup_ack_d2 = 1'b0, spur = 1'b0;
    logic [N:0]   res;
    assign res = {1'b0, r1} + {1'b0, r2} + {{N{1'b0}}, r3};

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1 <= '0; r2 <= '0; r3 <= 1'b0; st1 <= 1'b0;
            ack_m <= 1'b0; rdy_m <= 1'b0; data_m <= '0;
        end else begin
            ack_m <= we && !(sup_ack_d2 && addr == 3'd2);
            if (we) begin
                case (addr)
                    3'd1: r1 <= wdata;
                    3'd2: r2 <= wdata;
                    3'd3: r3 <= wdata[0];
                    default: ;
                endcase
            end
            st1   <= start;
            rdy_m <= st1 && !never_ready;
            data_m <= (addr == 3'd4) ? res[N-1:0] :
                      (addr == 3'd5) ? {{(N-1){1'b0}}, res[N]} : '0;
        end
    end
    assign ack   = ack_m;
    assign rdata = data_m;
    assign ready = rdy_m | spur;

    typedef struct { logic [N-1:0] sum; logic cout; logic err; int lat; int starts; } rsp_t;
    typedef struct { logic [2:0] addr; logic [N-1:0] data; } wr_t;
    rsp_t sb[$];
    wr_t  wq[$];

    int checks = 0, passed = 0;
    int cyc = 0, acc_edge = 0, hs_edge = 0, start_cnt = 0;
    logic prev_v = 1'b0, snap_cout = 1'b0, snap_err = 1'b0;
    logic [N-1:0] snap_sum = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        checks++;
        $display("FAIL %s: event missing", nm);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (req_valid && req_ready) acc_edge = cyc + 1;
            if (start) start_cnt++;
            if (we) begin
                if (wq.size() == 0) fail_now("wr_unexpected");
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(addr), 32'(w.addr));
                    chk("wr_data", 32'(wdata), 32'(w.data));
                end
            end
            if (rsp_valid) begin
                if (!prev_v) begin
                    snap_sum = rsp_sum; snap_cout = rsp_cout; snap_err = rsp_err;
                    if (sb.size() > 0) chk("latency", 32'(cyc - acc_edge + 1), 32'(sb[0].lat));
                end else begin
                    chk("rsp_stable", {22'd0, rsp_sum, rsp_cout, rsp_err},
                        {22'd0, snap_sum, snap_cout, snap_err});
                end
                chk("rsp_bus_quiet", {29'd0, we, start, req_ready}, 32'd0);
                if (rsp_ready) begin
                    hs_edge = cyc + 1;
                    if (sb.size() == 0) fail_now("rsp_unexpected");
                    else begin
                        e = sb.pop_front();
                        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        chk("start_pulses", 32'(start_cnt), 32'(e.starts));
                    end
                    start_cnt = 0;
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input logic [N-1:0] es, input logic ec, input logic ee,
                         input int lat, input int starts);
        rsp_t e;
        wr_t  w;
        int   n;
        e.sum = es; e.cout = ec; e.err = ee; e.lat = lat; e.starts = starts;
        sb.push_back(e);
        w.addr = 3'd1; w.data = a; wq.push_back(w);
        w.addr = 3'd2; w.data = b; wq.push_back(w);
        w.addr = 3'd3; w.data = {{(N-1){1'b0}}, c}; wq.push_back(w);
        op_a = a; op_b = b; cin = c; req_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (n == 50) fail_now("req_accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input int hold);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (n == 200) begin
            fail_now("rsp_timeout");
            return;
        end
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {8'd0, rsp_valid, rsp_sum, rsp_cout, rsp_err, addr, wdata, we, start}, 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 rstn = 1'b1;

        issue(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0, 14, 1);
        finish_rsp(0);
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 14, 1);
        finish_rsp(0);
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 14, 1);
        finish_rsp(0);

        // Response held off, then a second request right behind the handshake.
        issue(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 14, 1);
        finish_rsp(5);
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 14, 1);
        chk("b2b_accept_gap", 32'(acc_edge - hs_edge), 32'd1);
        finish_rsp(0);

        // Reset while waiting for the adder's ready.
        never_ready = 1'b1;
        issue(8'h77, 8'h11, 1'b0, 8'h88, 1'b0, 1'b0, 14, 1);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (start) break;
        end
        if (n == 50) fail_now("start_timeout");
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_outs", {8'd0, rsp_valid, rsp_sum, rsp_cout, rsp_err, addr, wdata, we, start}, 32'd0);
        sb.delete(); wq.delete(); start_cnt = 0; never_ready = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 14, 1);
        finish_rsp(0);

        // Spurious ready across both phases of the first write.
        issue(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, 14, 1);
        spur = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur = 1'b0;
        finish_rsp(0);

`ifdef ADDER_SEQ_WDOG_EN
        never_ready = 1'b1;
        issue(8'h5A, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 24, 1);
        finish_rsp(0);
        never_ready = 1'b0;
        sup_ack_d2 = 1'b1;
        issue(8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1, 20, 0);
        finish_rsp(0);
        sup_ack_d2 = 1'b0;
        wq.delete();
        @(posedge clk); #1;
        issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 14, 1);
        finish_rsp(0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
